// File: rtl/rcv_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rcv_control
// Purpose  : UART receive control: start-edge detect, packet sequencing,
//            stop-bit check, receive buffer and status. Option: RCV_OVERRUN_EN.
// Revision : 1.0
// ============================================================================
module rcv_control #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  serial_in,
  input  logic                  packet_done,
  input  logic [DATA_WIDTH-1:0] packet_data,
  input  logic                  stop_bit,
  input  logic                  data_read,
  output logic                  timer_enable,
  output logic                  sbc_clear,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_ready,
  output logic                  framing_error,
  output logic                  overrun_error
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    RECV     = 3'd2,
    STOP_CHK = 3'd3,
    LOAD     = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   prev_serial;
  logic   start_edge;

  assign start_edge = prev_serial & ~serial_in;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= IDLE;
      prev_serial <= 1'b1;
    end else begin
      state       <= next_state;
      prev_serial <= serial_in;
    end
  end

  always_comb begin
    next_state   = IDLE;
    timer_enable = 1'b0;
    sbc_clear    = 1'b0;
    case (state)
      IDLE:     next_state = start_edge ? CLEAR : IDLE;
      CLEAR: begin
        sbc_clear  = 1'b1;
        next_state = RECV;
      end
      RECV: begin
        timer_enable = 1'b1;
        next_state   = packet_done ? STOP_CHK : RECV;
      end
      STOP_CHK: next_state = stop_bit ? LOAD : IDLE;
      LOAD:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Buffer and framing status; a bad stop bit leaves the buffer alone.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_data       <= '1;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (state == CLEAR) begin
        framing_error <= 1'b0;
      end else if (state == STOP_CHK && !stop_bit) begin
        framing_error <= 1'b1;
      end

      if (state == LOAD) begin
        rx_data    <= packet_data;
        data_ready <= 1'b1;
      end else if (data_read) begin
        data_ready <= 1'b0;
      end
    end
  end

`ifdef RCV_OVERRUN_EN
  // A read coinciding with LOAD consumes the old packet, so no overrun.
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overrun_q <= 1'b0;
    end else if (state == LOAD) begin
      if (data_read) begin
        overrun_q <= 1'b0;
      end else if (data_ready) begin
        overrun_q <= 1'b1;
      end
    end else if (data_read) begin
      overrun_q <= 1'b0;
    end
  end

  assign overrun_error = overrun_q;
`else
  assign overrun_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rcv_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rcv_control
// Purpose  : Randomized scoreboard bench for rcv_control.
// Revision : 1.0
// ============================================================================
module tb_rcv_control;

  localparam int DW = 8;
`ifdef RCV_OVERRUN_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          n_rst;
  logic          serial_in;
  logic          packet_done;
  logic [DW-1:0] packet_data;
  logic          stop_bit;
  logic          data_read;
  logic          timer_enable;
  logic          sbc_clear;
  logic [DW-1:0] rx_data;
  logic          data_ready;
  logic          framing_error;
  logic          overrun_error;

  always #5 clk = ~clk;

  rcv_control #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .packet_done  (packet_done),
    .packet_data  (packet_data),
    .stop_bit     (stop_bit),
    .data_read    (data_read),
    .timer_enable (timer_enable),
    .sbc_clear    (sbc_clear),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .framing_error(framing_error),
    .overrun_error(overrun_error)
  );

  typedef struct packed {
    logic [DW-1:0] rx;
    logic          rdy;
    logic          fe;
    logic          ov;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state of the receive buffer as seen by a consumer
  logic [DW-1:0] m_rx;
  logic          m_rdy, m_fe, m_ov;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_rx = '1; m_rdy = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic model_read();
    m_rdy = 1'b0;
    m_ov  = 1'b0;
  endtask

  task automatic model_packet(input logic [DW-1:0] d, input logic s, input logic rd);
    exp_t e;
    if (s) begin
      if (rd) begin
        m_ov = 1'b0;
      end else if (OV_EN && m_rdy) begin
        m_ov = 1'b1;
      end
      m_rdy = 1'b1;
      m_rx  = d;
      m_fe  = 1'b0;
    end else begin
      m_fe = 1'b1;
    end
    e.rx = m_rx; e.rdy = m_rdy; e.fe = m_fe; e.ov = m_ov;
    sb.push_back(e);
  endtask

  // Monitor: end of the timed phase marks a completed packet; status settles two edges later.
  initial begin : monitor
    logic prev_te;
    exp_t e;
    prev_te = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_te && !timer_enable && sb.size() > 0) begin
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        check("rx_data", rx_data, e.rx);
        check("data_ready", data_ready, e.rdy);
        check("framing_error", framing_error, e.fe);
        check("overrun_error", overrun_error, e.ov);
      end
      prev_te = timer_enable;
    end
  end

  task automatic send_packet(input logic [DW-1:0] d, input logic s, input logic rd,
                             input int len, input logic end_low);
    tick(); serial_in = 1'b1;
    tick(); serial_in = 1'b0;
    model_packet(d, s, rd);
    @(negedge clk);
    @(negedge clk);
    check("sbc_clear_pulse", sbc_clear, 1'b1);
    check("te_in_clear", timer_enable, 1'b0);
    @(negedge clk);
    check("sbc_clear_end", sbc_clear, 1'b0);
    check("te_recv", timer_enable, 1'b1);
    for (int i = 0; i < len; i++) begin
      tick(); serial_in = 1'($urandom);
    end
    tick();
    packet_done = 1'b1; packet_data = d; stop_bit = s;
    serial_in = end_low ? 1'b0 : 1'b1;
    @(negedge clk);
    check("te_before_done", timer_enable, 1'b1);
    tick(); packet_done = 1'b0;
    @(negedge clk);
    check("te_stop_chk", timer_enable, 1'b0);
    tick(); data_read = rd;
    tick(); data_read = 1'b0;
    if (end_low) begin
      repeat (3) tick();
      check("no_false_start", {timer_enable, sbc_clear}, 2'b00);
    end
  endtask

  task automatic do_read();
    tick(); data_read = 1'b1; model_read();
    tick(); data_read = 1'b0;
  endtask

  task automatic idle_gap(input int g);
    for (int i = 0; i < g; i++) begin
      tick();
      serial_in   = 1'b1;
      packet_done = ($urandom_range(7) == 0);
      data_read   = ($urandom_range(5) == 0);
      if (data_read) model_read();
    end
    tick(); packet_done = 1'b0; data_read = 1'b0;
    @(negedge clk);
    check("gap_te", timer_enable, 1'b0);
    check("gap_ready", data_ready, m_rdy);
    check("gap_ov", overrun_error, m_ov);
  endtask

  initial begin : driver
    n_rst = 1'b0; serial_in = 1'b1; packet_done = 1'b0;
    packet_data = '0; stop_bit = 1'b1; data_read = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check("rst_rx_data", rx_data, 8'hFF);
    check("rst_status", {data_ready, framing_error, overrun_error}, 3'b000);
    check("rst_ctrl", {timer_enable, sbc_clear}, 2'b00);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_te", timer_enable, 1'b0);
    end
    check("idle_rx_data", rx_data, 8'hFF);

    send_packet(8'hA5, 1'b1, 1'b0, 88, 1'b0);
    do_read();
    send_packet(8'hA5, 1'b0, 1'b0, 88, 1'b1);
    send_packet(8'h5A, 1'b1, 1'b0, 40, 1'b0);
    do_read();
    send_packet(8'h3C, 1'b1, 1'b0, 30, 1'b0);
    send_packet(8'hC3, 1'b1, 1'b0, 30, 1'b0);
    do_read();
    send_packet(8'h3C, 1'b1, 1'b0, 30, 1'b0);
    send_packet(8'hC3, 1'b1, 1'b1, 30, 1'b0);

    // Reset pulse in the middle of a packet
    tick(); serial_in = 1'b1;
    tick(); serial_in = 1'b0;
    repeat (6) tick();
    n_rst = 1'b0; serial_in = 1'b1;
    tick(); n_rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("midrst_te", timer_enable, 1'b0);
    check("midrst_rx_data", rx_data, 8'hFF);
    check("midrst_status", {data_ready, framing_error, overrun_error}, 3'b000);
    send_packet(8'h77, 1'b1, 1'b0, 20, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [DW-1:0] d;
      logic          s, rd;
      d  = DW'($urandom);
      s  = ($urandom_range(3) != 0);
      rd = s && ($urandom_range(2) == 0);
      send_packet(d, s, rd, $urandom_range(100, 5), 1'($urandom));
      if ($urandom_range(1) == 0) idle_gap($urandom_range(12, 1));
    end

    repeat (5) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/rcv_control.md
# rcv_control

Receive control unit for the UART receiver. It detects the start-bit falling edge on the synchronized serial line and sequences the bit-period timer through a packet. It checks the stop bit, loads the shifted data into the receive buffer, and reports data_ready, framing and overrun status. It sits directly upstream of the shift timer: it drives timer_enable and the timer/shift-register clear, and consumes shift_strobe-derived packet_done.

## Interface
Parameters:
- DATA_WIDTH, 8, data bits per packet

Ports:
- clk  in  1  system clock, all state updates on rising edge
- n_rst  in  1  reset; one clock, synchronous, active-low
- serial_in  in  1  already-synchronized receive line, idle high
- packet_done  in  1  one-cycle pulse from timer: all data and stop bits shifted
- packet_data  in  DATA_WIDTH  parallel data from the receive shift register
- stop_bit  in  1  stop-bit value captured by the shift register
- data_read  in  1  consumer acknowledge of rx_data, one-cycle pulse
- timer_enable  out  1  high while the packet is being timed
- sbc_clear  out  1  one-cycle clear to timer and shift register at packet start
- rx_data  out  DATA_WIDTH  receive buffer contents
- data_ready  out  1  rx_data holds an unread packet
- framing_error  out  1  last packet had stop_bit = 0
- overrun_error  out  1  unread packet was overwritten

## Operation
- Edge detect: register prev_serial (reset 1). start_edge = prev_serial & ~serial_in, evaluated only in IDLE. Edges are ignored in other states.
- FSM states and transitions:
  - IDLE: start_edge -> CLEAR.
  - CLEAR: sbc_clear = 1 and framing_error <= 0. -> RECV unconditionally.
  - RECV: timer_enable = 1. packet_done -> STOP_CHK; otherwise stay.
  - STOP_CHK: stop_bit = 1 -> LOAD. stop_bit = 0 -> IDLE with framing_error <= 1.
  - LOAD: rx_data <= packet_data, data_ready <= 1. -> IDLE.
- packet_done outside RECV is ignored.
- Unused state encodings -> IDLE.
- Buffer and status rules, in priority order:
  - LOAD and data_ready = 1 and data_read = 0: overrun_error <= 1.
  - LOAD with data_read = 1: data_ready stays 1 and overrun_error <= 0. The new data is the unread packet.
  - data_read without LOAD: data_ready <= 0 and overrun_error <= 0.
  - Otherwise data_ready and overrun_error hold.
- On a framing error, rx_data and data_ready are untouched.
- framing_error holds until the next CLEAR.

## Timing
- Reset values, applied at the first rising edge with n_rst = 0, from any state including mid-packet:
  - FSM = IDLE, prev_serial = 1.
  - timer_enable = 0, sbc_clear = 0.
  - rx_data = all ones, data_ready = 0, framing_error = 0, overrun_error = 0.
- timer_enable and sbc_clear are Moore outputs decoded from the state register.
- Status outputs are registered.
- Cycle latencies:
  - serial_in falls at edge N (sampled N-1 high, N low): CLEAR at N+1, sbc_clear high for cycle N+1.
  - RECV (timer_enable high) from N+2.
  - packet_done high at edge M: STOP_CHK during cycle M+1.
  - Good stop bit: LOAD during M+2, data_ready and rx_data visible after edge M+3, FSM back in IDLE.
  - Bad stop bit: framing_error high after edge M+2.
- Back-to-back packets: a start edge is accepted in the first IDLE cycle after LOAD or STOP_CHK.
- A line already low on return to IDLE is not a new edge.
- data_read takes effect on the next edge. A data_read while data_ready = 0 is harmless: it clears overrun only.

## Configuration
- RCV_OVERRUN_EN defined: overrun detection as above.
- RCV_OVERRUN_EN undefined:
  - overrun_error is constant 0 and its logic is removed.
  - LOAD still overwrites rx_data regardless of data_ready.

## Test plan
- Reset, then idle line high for 20 cycles -> all outputs at reset values, timer_enable stays 0.
- serial_in falls, packet_done pulses 90 cycles later with packet_data = 8'hA5 and stop_bit = 1:
  - sbc_clear is a one-cycle pulse one cycle after the fall; timer_enable is high until STOP_CHK.
  - rx_data = 8'hA5 and data_ready = 1 three cycles after packet_done.
- Same packet with stop_bit = 0 -> framing_error = 1, data_ready = 0, rx_data unchanged. The next good packet clears framing_error in its CLEAR cycle.
- Two packets 8'h3C then 8'hC3 with no data_read:
  - RCV_OVERRUN_EN defined: overrun_error = 1, rx_data = 8'hC3.
  - RCV_OVERRUN_EN undefined: overrun_error = 0.
- data_read asserted in the LOAD cycle of the second packet -> data_ready = 1, overrun_error = 0, rx_data = 8'hC3.
- n_rst low for one cycle during RECV -> IDLE, timer_enable = 0, rx_data = all ones. A following packet is received correctly.
